// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rf_pkg
//  Purpose : Shared types and helpers for the rename register file.
//            - rename_entry_t : one rename-table entry {busy, ROB tag}
//            - ckpt_mask_t    : one bit per checkpoint slot
//            - RF_X0          : index of the hard-wired zero register
//            - port_lsb()     : LSB of port k inside a packed multi-port bus
//  Revision: 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int RF_ROB_WIDTH = 4;
    localparam int RF_CKPT_NUM  = 4;
    localparam int RF_X0        = 0;

    typedef struct packed {
        logic                    busy;
        logic [RF_ROB_WIDTH-1:0] tag;
    } rename_entry_t;

    typedef logic [RF_CKPT_NUM-1:0] ckpt_mask_t;

    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_ckpt_alloc.sv
`default_nettype none
// ============================================================================
//  Module  : rf_ckpt_alloc
//  Purpose : Checkpoint slot allocator for the rename register file.
//            Tracks which slots hold a live snapshot, hands out the lowest
//            free slot, and keeps relative allocation age so a restore can
//            free every slot allocated after the restored one.
//  Ports   : clkIn/rstIn (sync, active-low), rdyIn (enable), clrIn (flush)
//            saveIn             - allocate ckptId this cycle (pre-qualified)
//            resolveFlag/Id     - free one slot
//            restoreFlag/Id     - free the slot and all younger slots
//            ckptId / ckptFull  - lowest free slot / no free slot
//  Revision: 1.0 - initial release
// ============================================================================
module rf_ckpt_alloc
    import rf_pkg::*;
#(
    parameter int CKPT_NUM   = RF_CKPT_NUM,
    parameter int CKPT_WIDTH = 2
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  rdyIn,
    input  logic                  clrIn,
    input  logic                  saveIn,
    input  logic                  resolveFlag,
    input  logic [CKPT_WIDTH-1:0] resolveId,
    input  logic                  restoreFlag,
    input  logic [CKPT_WIDTH-1:0] restoreId,
    output logic [CKPT_WIDTH-1:0] ckptId,
    output logic                  ckptFull
);

    ckpt_mask_t r_valid;
    // r_older[i][j] = 1 when slot j was allocated before slot i.
    ckpt_mask_t r_older [CKPT_NUM];
    ckpt_mask_t w_younger;
    ckpt_mask_t w_validNext;

    // Lowest free slot; scanning downward lets the lowest index win.
    always_comb begin
        ckptId = '0;
        for (int i = CKPT_NUM - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                ckptId = CKPT_WIDTH'(i);
            end
        end
    end

    assign ckptFull = &r_valid;

    always_comb begin
        for (int j = 0; j < CKPT_NUM; j++) begin
            w_younger[j] = r_valid[j] & r_older[j][restoreId];
        end
    end

    always_comb begin
        w_validNext = r_valid;
        if (restoreFlag) begin
            w_validNext = r_valid & ~w_younger & ~(ckpt_mask_t'(1) << restoreId);
        end else if (saveIn) begin
            w_validNext[ckptId] = 1'b1;
        end
        if (resolveFlag) begin
            w_validNext[resolveId] = 1'b0;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_valid <= '0;
            for (int i = 0; i < CKPT_NUM; i++) begin
                r_older[i] <= '0;
            end
        end else if (rdyIn) begin
            r_valid <= clrIn ? '0 : w_validNext;
            if (saveIn) begin
                // New slot is the youngest: nobody is younger than it, and
                // every currently live slot is older than it.
                for (int j = 0; j < CKPT_NUM; j++) begin
                    r_older[j][ckptId] <= 1'b0;
                end
                r_older[ckptId] <= r_valid;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_register_file.sv
`default_nettype none
// ============================================================================
//  Module  : rename_register_file
//  Purpose : Architectural register file with a ROB-tag rename table and a
//            bank of rename-table checkpoints for branch recovery.
//  Ports   : clkIn, rstIn (sync, active-low), rdyIn (enable), clrIn (flush)
//            issueFlag/Reg/ROB  - rename rd to a ROB tag
//            rsFlag -> rsBusy/rsData/rsRename : READ_PORTS combinational reads
//            writeFlag/Src/Reg/Data : ROB commit
//            ckptSave, ckptId, ckptFull : checkpoint save / allocation state
//            resolveFlag/Id, restoreFlag/Id : branch resolve / mispredict
//  Config  : RF_BYPASS_EN - when defined, reads see a same-cycle matching
//            commit (data = writeData, busy = 0).
//  Revision: 1.0 - initial release
// ============================================================================
module rename_register_file
    import rf_pkg::*;
#(
    parameter int ROB_WIDTH  = RF_ROB_WIDTH,
    parameter int REG_WIDTH  = 5,
    parameter int READ_PORTS = 2,
    parameter int CKPT_NUM   = RF_CKPT_NUM,
    parameter int CKPT_WIDTH = 2
) (
    input  logic                            clkIn,
    input  logic                            rstIn,
    input  logic                            rdyIn,
    input  logic                            clrIn,
    input  logic                            issueFlag,
    input  logic [REG_WIDTH-1:0]            issueReg,
    input  logic [ROB_WIDTH-1:0]            issueROB,
    input  logic [READ_PORTS*REG_WIDTH-1:0] rsFlag,
    output logic [READ_PORTS-1:0]           rsBusy,
    output logic [READ_PORTS*32-1:0]        rsData,
    output logic [READ_PORTS*ROB_WIDTH-1:0] rsRename,
    input  logic                            writeFlag,
    input  logic [ROB_WIDTH-1:0]            writeSrc,
    input  logic [REG_WIDTH-1:0]            writeReg,
    input  logic [31:0]                     writeData,
    input  logic                            ckptSave,
    output logic [CKPT_WIDTH-1:0]           ckptId,
    output logic                            ckptFull,
    input  logic                            resolveFlag,
    input  logic [CKPT_WIDTH-1:0]           resolveId,
    input  logic                            restoreFlag,
    input  logic [CKPT_WIDTH-1:0]           restoreId
);

    localparam int c_NREG = 2 ** REG_WIDTH;

    rename_entry_t r_table [c_NREG];
    logic [31:0]   r_data  [c_NREG];
    rename_entry_t r_ckpt  [CKPT_NUM][c_NREG];

    rename_entry_t w_liveCommit [c_NREG];
    rename_entry_t w_liveNext   [c_NREG];
    rename_entry_t w_ckptCommit [CKPT_NUM][c_NREG];
    logic          w_saveEn;

    // A save is dropped on restore, flush, or when every slot is taken.
    assign w_saveEn = rdyIn & ckptSave & ~restoreFlag & ~clrIn & ~ckptFull;

    rf_ckpt_alloc #(
        .CKPT_NUM   (CKPT_NUM),
        .CKPT_WIDTH (CKPT_WIDTH)
    ) u_alloc (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .rdyIn       (rdyIn),
        .clrIn       (clrIn),
        .saveIn      (w_saveEn),
        .resolveFlag (resolveFlag),
        .resolveId   (resolveId),
        .restoreFlag (restoreFlag),
        .restoreId   (restoreId),
        .ckptId      (ckptId),
        .ckptFull    (ckptFull)
    );

    // Commit clears busy only when the entry still waits on this exact tag;
    // a younger rename of the same register must stay busy.
    always_comb begin
        for (int i = 0; i < c_NREG; i++) begin
            w_liveCommit[i] = r_table[i];
            if (writeFlag && writeReg == REG_WIDTH'(i) &&
                r_table[i].busy && r_table[i].tag == writeSrc) begin
                w_liveCommit[i].busy = 1'b0;
            end
            for (int c = 0; c < CKPT_NUM; c++) begin
                w_ckptCommit[c][i] = r_ckpt[c][i];
                if (writeFlag && writeReg == REG_WIDTH'(i) &&
                    r_ckpt[c][i].busy && r_ckpt[c][i].tag == writeSrc) begin
                    w_ckptCommit[c][i].busy = 1'b0;
                end
            end
        end
    end

    // Restore replaces the whole table; otherwise the issue overrides commit.
    always_comb begin
        for (int i = 0; i < c_NREG; i++) begin
            if (restoreFlag) begin
                w_liveNext[i] = w_ckptCommit[restoreId][i];
            end else begin
                w_liveNext[i] = w_liveCommit[i];
                if (issueFlag && issueReg == REG_WIDTH'(i) && i != RF_X0) begin
                    w_liveNext[i] = '{busy: 1'b1, tag: issueROB};
                end
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_table[i] <= '0;
                r_data[i]  <= '0;
            end
        end else if (rdyIn) begin
            if (writeFlag && writeReg != REG_WIDTH'(RF_X0)) begin
                r_data[writeReg] <= writeData;
            end
            for (int i = 0; i < c_NREG; i++) begin
                r_table[i].busy <= clrIn ? 1'b0 : w_liveNext[i].busy;
                r_table[i].tag  <= w_liveNext[i].tag;
            end
        end
    end

    // Snapshot contents need no reset: a slot is only read while valid.
    always_ff @(posedge clkIn) begin
        if (rstIn && rdyIn) begin
            for (int c = 0; c < CKPT_NUM; c++) begin
                for (int i = 0; i < c_NREG; i++) begin
                    r_ckpt[c][i] <= (w_saveEn && ckptId == CKPT_WIDTH'(c)) ?
                                    w_liveNext[i] : w_ckptCommit[c][i];
                end
            end
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_read_port
        logic [REG_WIDTH-1:0] w_idx;
        rename_entry_t        w_entry;
        logic                 w_isX0;
        logic                 w_byp;

        assign w_idx   = rsFlag[port_lsb(k, REG_WIDTH) +: REG_WIDTH];
        assign w_entry = r_table[w_idx];
        assign w_isX0  = (w_idx == REG_WIDTH'(RF_X0));
`ifdef RF_BYPASS_EN
        assign w_byp   = writeFlag && writeReg == w_idx && !w_isX0 &&
                         w_entry.tag == writeSrc;
`else
        assign w_byp   = 1'b0;
`endif
        assign rsBusy[k] = !w_isX0 && w_entry.busy && !w_byp;
        assign rsData[port_lsb(k, 32) +: 32] =
            w_isX0 ? 32'd0 : (w_byp ? writeData : r_data[w_idx]);
        assign rsRename[port_lsb(k, ROB_WIDTH) +: ROB_WIDTH] =
            w_isX0 ? '0 : w_entry.tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_register_file.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rename_register_file
//  Purpose : Self-checking bench for rename_register_file. A behavioural
//            model keeps the live table as flat arrays and the checkpoints
//            as an allocation-ordered list of snapshots.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rename_register_file;

    logic        clkIn = 1'b0;
    logic        rstIn, rdyIn, clrIn;
    logic        issueFlag;
    logic [4:0]  issueReg;
    logic [3:0]  issueROB;
    logic [9:0]  rsFlag;
    logic [1:0]  rsBusy;
    logic [63:0] rsData;
    logic [7:0]  rsRename;
    logic        writeFlag;
    logic [3:0]  writeSrc;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        ckptSave;
    logic [1:0]  ckptId;
    logic        ckptFull;
    logic        resolveFlag;
    logic [1:0]  resolveId;
    logic        restoreFlag;
    logic [1:0]  restoreId;

    always #5 clkIn = ~clkIn;

    rename_register_file dut (
        .clkIn(clkIn), .rstIn(rstIn), .rdyIn(rdyIn), .clrIn(clrIn),
        .issueFlag(issueFlag), .issueReg(issueReg), .issueROB(issueROB),
        .rsFlag(rsFlag), .rsBusy(rsBusy), .rsData(rsData), .rsRename(rsRename),
        .writeFlag(writeFlag), .writeSrc(writeSrc), .writeReg(writeReg),
        .writeData(writeData), .ckptSave(ckptSave), .ckptId(ckptId),
        .ckptFull(ckptFull), .resolveFlag(resolveFlag), .resolveId(resolveId),
        .restoreFlag(restoreFlag), .restoreId(restoreId)
    );

    typedef struct {
        int              slot;
        logic [31:0]     busy;
        logic [31:0][3:0] tag;
    } snap_t;

    logic [31:0]      m_busy;
    logic [31:0][3:0] m_tag;
    logic [31:0]      m_data [32];
    snap_t            q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int s = 0; s < 4; s++) begin
            bit used = 0;
            foreach (q[j]) if (q[j].slot == s) used = 1;
            if (!used) return s;
        end
        return 0;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [4:0]  idx;
            logic        eb;
            logic [31:0] ed;
            idx = rsFlag[k*5 +: 5];
            eb  = (idx != 0) && m_busy[idx];
            ed  = (idx == 0) ? 32'd0 : m_data[idx];
`ifdef RF_BYPASS_EN
            if (writeFlag && writeReg == idx && idx != 0 && m_tag[idx] == writeSrc) begin
                eb = 1'b0;
                ed = writeData;
            end
`endif
            chk($sformatf("busy[%0d] x%0d", k, idx), 32'(rsBusy[k]), 32'(eb));
            chk($sformatf("data[%0d] x%0d", k, idx), rsData[k*32 +: 32], ed);
            if (eb) chk($sformatf("rename[%0d] x%0d", k, idx), 32'(rsRename[k*4 +: 4]), 32'(m_tag[idx]));
            if (idx == 0) chk($sformatf("rename[%0d] x0", k), 32'(rsRename[k*4 +: 4]), 32'd0);
        end
        chk("ckptFull", 32'(ckptFull), 32'(q.size() == 4));
        chk("ckptId", 32'(ckptId), 32'(lowest_free()));
    endtask

    task automatic model_step();
        int  freeid;
        bit  full;
        if (!rstIn) begin
            m_busy = '0;
            m_tag  = '0;
            for (int i = 0; i < 32; i++) m_data[i] = 32'd0;
            q.delete();
            return;
        end
        if (!rdyIn) return;
        freeid = lowest_free();
        full   = (q.size() == 4);
        if (writeFlag && writeReg != 0) begin
            m_data[writeReg] = writeData;
            if (m_busy[writeReg] && m_tag[writeReg] == writeSrc) m_busy[writeReg] = 1'b0;
            for (int j = 0; j < q.size(); j++)
                if (q[j].busy[writeReg] && q[j].tag[writeReg] == writeSrc) q[j].busy[writeReg] = 1'b0;
        end
        if (restoreFlag) begin
            for (int j = 0; j < q.size(); j++) begin
                if (q[j].slot == int'(restoreId)) begin
                    m_busy = q[j].busy;
                    m_tag  = q[j].tag;
                    while (q.size() > j) void'(q.pop_back());
                    break;
                end
            end
        end else begin
            if (issueFlag && issueReg != 0) begin
                m_busy[issueReg] = 1'b1;
                m_tag[issueReg]  = issueROB;
            end
            if (ckptSave && !full) begin
                snap_t s;
                s.slot = freeid;
                s.busy = m_busy;
                s.tag  = m_tag;
                q.push_back(s);
            end
        end
        if (resolveFlag) begin
            for (int j = 0; j < q.size(); j++) begin
                if (q[j].slot == int'(resolveId)) begin
                    q.delete(j);
                    break;
                end
            end
        end
        if (clrIn) begin
            m_busy = '0;
            q.delete();
        end
    endtask

    // Inputs are already applied; check, advance model, clock once.
    task automatic tick(input bit do_chk);
        #1;
        if (do_chk) check_outputs();
        model_step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic idle();
        rstIn = 1'b1; rdyIn = 1'b1; clrIn = 1'b0;
        issueFlag = 1'b0; issueReg = '0; issueROB = '0;
        writeFlag = 1'b0; writeSrc = '0; writeReg = '0; writeData = '0;
        ckptSave = 1'b0; resolveFlag = 1'b0; resolveId = '0;
        restoreFlag = 1'b0; restoreId = '0;
    endtask

    task automatic probe(input string tag, input logic [4:0] r, input logic eb,
                         input logic [3:0] er, input logic [31:0] ed);
        idle();
        rsFlag = {5'd0, r};
        #1;
        chk({tag, " busy"}, 32'(rsBusy[0]), 32'(eb));
        chk({tag, " data"}, rsData[31:0], ed);
        if (eb) chk({tag, " rename"}, 32'(rsRename[3:0]), 32'(er));
    endtask

    task automatic do_issue(input logic [4:0] r, input logic [3:0] t);
        idle(); issueFlag = 1'b1; issueReg = r; issueROB = t; tick(1);
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        idle(); writeFlag = 1'b1; writeReg = r; writeSrc = t; writeData = d; tick(1);
    endtask

    task automatic do_save();
        idle(); ckptSave = 1'b1; tick(1);
    endtask

    task automatic do_restore(input logic [1:0] id);
        idle(); restoreFlag = 1'b1; restoreId = id; tick(1);
    endtask

    initial begin
        idle();
        rsFlag = '0;
        rstIn  = 1'b0;
        tick(0);
        tick(1);

        // Reset and x0
        do_issue(5'd0, 4'd5);
        probe("x0", 5'd0, 1'b0, 4'd0, 32'd0);
        chk("rst ckptId", 32'(ckptId), 32'd0);
        chk("rst ckptFull", 32'(ckptFull), 32'd0);

        // Rename then commit
        do_issue(5'd3, 4'd2);
        probe("x3 renamed", 5'd3, 1'b1, 4'd2, 32'd0);
        do_commit(5'd3, 4'd2, 32'hDEADBEEF);
        probe("x3 committed", 5'd3, 1'b0, 4'd0, 32'hDEADBEEF);
        do_issue(5'd3, 4'd4);
        do_commit(5'd3, 4'd1, 32'h0000_1111);
        probe("x3 stale", 5'd3, 1'b1, 4'd4, 32'h0000_1111);

        // Same-cycle commit and issue
        idle();
        writeFlag = 1'b1; writeReg = 5'd7; writeSrc = 4'd4; writeData = 32'hCAFE0007;
        issueFlag = 1'b1; issueReg = 5'd7; issueROB = 4'd6;
        tick(1);
        probe("x7 issue wins", 5'd7, 1'b1, 4'd6, 32'hCAFE0007);

        // Checkpoint and restore
        do_issue(5'd5, 4'd1);
        do_save();
        do_issue(5'd5, 4'd3);
        do_save();
        do_restore(2'd0);
        probe("x5 restored", 5'd5, 1'b1, 4'd1, 32'd0);
        chk("restore ckptId", 32'(ckptId), 32'd0);
        chk("restore ckptFull", 32'(ckptFull), 32'd0);

        // Commit during checkpoint
        do_issue(5'd9, 4'd2);
        do_save();
        do_commit(5'd9, 4'd2, 32'h0000_0099);
        do_restore(2'd0);
        probe("x9 ckpt commit", 5'd9, 1'b0, 4'd0, 32'h0000_0099);

        // Full and resolve
        for (int i = 0; i < 4; i++) do_save();
        chk("full after 4", 32'(ckptFull), 32'd1);
        do_save();
        chk("full after 5th", 32'(ckptFull), 32'd1);
        idle(); resolveFlag = 1'b1; resolveId = 2'd2; tick(1);
        chk("resolve ckptFull", 32'(ckptFull), 32'd0);
        chk("resolve ckptId", 32'(ckptId), 32'd2);

        // Same-cycle commit read of x3 (bypass-dependent, model decides)
        idle();
        rsFlag = {5'd0, 5'd3};
        writeFlag = 1'b1; writeReg = 5'd3; writeSrc = 4'd4; writeData = 32'h3333_3333;
        tick(1);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rstIn       = ($urandom_range(63) != 0);
            rdyIn       = ($urandom_range(7) != 0);
            clrIn       = ($urandom_range(31) == 0);
            issueFlag   = 1'($urandom_range(1));
            issueReg    = 5'($urandom);
            issueROB    = 4'($urandom);
            writeFlag   = 1'($urandom_range(1));
            writeReg    = 5'($urandom);
            writeSrc    = ($urandom_range(1) != 0) ? m_tag[writeReg] : 4'($urandom);
            writeData   = $urandom;
            rsFlag      = 10'($urandom);
            if ($urandom_range(1) != 0) rsFlag[4:0] = writeReg;
            ckptSave    = ($urandom_range(3) == 0);
            resolveFlag = ($urandom_range(3) == 0);
            resolveId   = 2'($urandom);
            restoreFlag = (q.size() > 0) && ($urandom_range(7) == 0);
            restoreId   = '0;
            if (restoreFlag) restoreId = 2'(q[$urandom_range(q.size() - 1)].slot);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
